lzc_denormalizer: RTL and testbench

Sequential inverse of the leading-zero-count path. It takes a left-normalized mantissa plus its leading-zero count and zero flag, and rebuilds the original unnormalized operand with a right shift. It runs one logarithmic shift stage per cycle. It sits downstream of normalize/compute datapaths that must hand back the operand in its original alignment, and uses a valid/ready handshake on both sides.

---
 rtl/lzc_denormalizer_if.sv | 26 ++
 rtl/lzc_denormalizer.sv | 94 +++++++++
 tb/tb_lzc_denormalizer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/lzc_denormalizer_if.sv
// Handshake bundle for lzc_denormalizer: normalized operand in, reconstructed operand out.
// The master side feeds beats and drives out_ready; the slave side is the denormalizer.
interface lzc_denormalizer_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned COUNT = $clog2(WIDTH)
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_mant;
    logic [COUNT:0]   in_nz;
    logic             in_zero;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_err;

    modport master (
        output in_valid, in_mant, in_nz, in_zero, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_mant, in_nz, in_zero, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/lzc_denormalizer.sv
// Rebuilds an unnormalized operand from a left-normalized mantissa and its leading-zero
// count, applying one power-of-two right-shift stage per cycle.
module lzc_denormalizer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned COUNT = $clog2(WIDTH)
) (
    input logic                clk,
    input logic                rst_n,
    lzc_denormalizer_if.slave  bus
);
    localparam int unsigned NzW    = COUNT + 1;
    localparam int unsigned StageW = (COUNT > 1) ? $clog2(COUNT) : 1;

    if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0 || COUNT != $clog2(WIDTH)) begin : g_bad_width
        $error("lzc_denormalizer: WIDTH must be a power of two >= 2 and COUNT = clog2(WIDTH)");
    end

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    data_q, data_d;
    logic [COUNT-1:0]    cnt_q, cnt_d;
    logic [StageW-1:0]   stage_q, stage_d;
    logic                err_q, err_d;

    logic                nz_full;
    logic                nz_over;
    logic [WIDTH-1:0]    shamt;

    // A count of exactly WIDTH is a legal all-zero encoding; only above it is malformed.
    assign nz_full = bus.in_nz >= NzW'(WIDTH);
    assign nz_over = bus.in_nz >  NzW'(WIDTH);
    assign shamt   = WIDTH'(1) << stage_q;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    data_d  = bus.in_mant;
                    cnt_d   = bus.in_nz[COUNT-1:0];
                    stage_d = '0;
                    err_d   = nz_over | (!bus.in_zero && !nz_full && !bus.in_mant[WIDTH-1]);
                    if (bus.in_zero || nz_full) begin
                        data_d  = '0;
                        state_d = StDone;
                    end else begin
                        state_d = StShift;
                    end
                end
            end
            StShift: begin
                if (cnt_q[stage_q]) begin
                    data_d = data_q >> shamt;
                end
                stage_d = stage_q + StageW'(1);
                if (stage_q == StageW'(COUNT - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            data_q  <= '0;
            cnt_q   <= '0;
            stage_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.out_data  = data_q;
    assign bus.out_err   = err_q;
endmodule

// File: tb/tb_lzc_denormalizer.sv
// Directed-vector bench for lzc_denormalizer at WIDTH=16: latency, data, error flag,
// backpressure and asynchronous reset behaviour.
module tb_lzc_denormalizer;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    lzc_denormalizer_if #(.WIDTH(16)) bus ();

    lzc_denormalizer #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one beat and checks latency (edges after the accepting edge), data and error.
    task automatic do_beat(input logic [15:0] mant, input logic [4:0] nz, input logic zero,
                           input logic [15:0] exp_data, input logic exp_err,
                           input int exp_lat, input bit do_hs, input string name);
        int cyc;
        cyc = 0;
        while (!bus.in_ready && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        bus.in_valid = 1'b1;
        bus.in_mant  = mant;
        bus.in_nz    = nz;
        bus.in_zero  = zero;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_mant  = 16'hFFFF;
        bus.in_nz    = 5'd0;
        bus.in_zero  = 1'b0;
        cyc = 0;
        while (!bus.out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_cmp++;
        if (cyc !== exp_lat) begin
            n_bad++;
            $display("FAIL %s latency: got %0d edges, want %0d", name, cyc, exp_lat);
        end
        n_cmp++;
        if (bus.out_data !== exp_data) begin
            n_bad++;
            $display("FAIL %s data: got %h, want %h", name, bus.out_data, exp_data);
        end
        n_cmp++;
        if (bus.out_err !== exp_err) begin
            n_bad++;
            $display("FAIL %s err: got %b, want %b", name, bus.out_err, exp_err);
        end
        if (do_hs) begin
            @(posedge clk); #1;
            n_cmp++;
            if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL %s post-handshake: got ready=%b valid=%b, want ready=1 valid=0",
                         name, bus.in_ready, bus.out_valid);
            end
        end
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0000 || bus.out_err !== 1'b0 ||
            bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset: got valid=%b data=%h err=%b ready=%b, want 0 0000 0 1",
                     bus.out_valid, bus.out_data, bus.out_err, bus.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_shift();
        do_beat(16'h8000, 5'd4,  1'b0, 16'h0800, 1'b0, 4, 1'b1, "nz4");
        do_beat(16'hB3C0, 5'd0,  1'b0, 16'hB3C0, 1'b0, 4, 1'b1, "nz0");
        do_beat(16'h8000, 5'd15, 1'b0, 16'h0001, 1'b0, 4, 1'b1, "nz15");
        do_beat(16'hC000, 5'd5,  1'b0, 16'h0600, 1'b0, 4, 1'b1, "nz5");
    endtask

    // Zero/overflow beats reach DONE on the accepting edge itself.
    task automatic test_zero_overflow();
        do_beat(16'h1234, 5'd16, 1'b1, 16'h0000, 1'b0, 0, 1'b1, "zero16");
        do_beat(16'h1234, 5'd17, 1'b1, 16'h0000, 1'b1, 0, 1'b1, "zero17");
        do_beat(16'h0000, 5'd16, 1'b0, 16'h0000, 1'b0, 0, 1'b1, "nz16");
        do_beat(16'h8000, 5'd20, 1'b0, 16'h0000, 1'b1, 0, 1'b1, "nz20");
    endtask

    task automatic test_not_normalized();
        do_beat(16'h4000, 5'd2, 1'b0, 16'h1000, 1'b1, 4, 1'b1, "unnorm");
        do_beat(16'hFFFF, 5'd1, 1'b0, 16'h7FFF, 1'b0, 4, 1'b1, "ones_nz1");
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        do_beat(16'hF000, 5'd3, 1'b0, 16'h1E00, 1'b0, 4, 1'b0, "bp");
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_mant  = 16'($urandom);
            bus.in_nz    = 5'($urandom_range(0, 16));
            bus.in_zero  = 1'($urandom);
            @(posedge clk); #1;
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h1E00 || bus.in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL bp hold %0d: got valid=%b data=%h ready=%b, want 1 1e00 0",
                         i, bus.out_valid, bus.out_data, bus.in_ready);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL bp release: got valid=%b ready=%b, want 0 1",
                     bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_async_reset();
        bus.in_valid = 1'b1;
        bus.in_mant  = 16'h8000;
        bus.in_nz    = 5'd4;
        bus.in_zero  = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL mid-shift: got ready=%b valid=%b, want 0 0",
                     bus.in_ready, bus.out_valid);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0000 || bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL async reset: got valid=%b data=%h ready=%b, want 0 0000 1",
                     bus.out_valid, bus.out_data, bus.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_beat(16'h8000, 5'd1, 1'b0, 16'h4000, 1'b0, 4, 1'b1, "after_reset");
    endtask

    task automatic test_back_to_back();
        do_beat(16'h8000, 5'd8,  1'b0, 16'h0080, 1'b0, 4, 1'b1, "b2b_a");
        do_beat(16'hA5A5, 5'd16, 1'b1, 16'h0000, 1'b0, 0, 1'b1, "b2b_b");
        do_beat(16'h9000, 5'd12, 1'b0, 16'h0009, 1'b0, 4, 1'b1, "b2b_c");
    endtask

    initial begin
        n_cmp         = 0;
        n_bad         = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_mant   = 16'h0000;
        bus.in_nz     = 5'd0;
        bus.in_zero   = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_shift();
        test_zero_overflow();
        test_not_normalized();
        test_backpressure();
        test_async_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
